// File: rtl/datapath_param.sv
// Parametrised single-cycle datapath core with an 8-op ISA,
// carry flag, run/stall control, retired counter and debug read port.
module datapath_param #(
  parameter int W    = 4,
  parameter int NREG = 4,
  parameter int PCW  = 4,
  parameter int CNTW = 8,
  localparam int RB   = $clog2(NREG),
  localparam int IMMW = (W > PCW) ? W : PCW,
  localparam int IW   = 3 + 3*RB + IMMW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [IW-1:0]   ins,
  output logic [PCW-1:0]  pc,
  output logic            halted,
  output logic            carry,
  output logic [CNTW-1:0] retired,
  input  logic [RB-1:0]   dbg_sel,
  output logic [W-1:0]    dbg_data
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_LDI  = 3'b100,
    OP_BEQ  = 3'b101,
    OP_JMP  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  state_t state, state_n;

  logic [W-1:0] rf [NREG];

  op_t            op;
  logic [RB-1:0]  rw, ra, rb;
  logic [IMMW-1:0] imm;
  logic [W-1:0]   a, b;
  logic [W:0]     add_r;
  logic [PCW-1:0] pc_inc, pc_n;
  logic           carry_n;
  logic           we, retire;
  logic [W-1:0]   wdata;

  assign op  = op_t'(ins[IW-1 -: 3]);
  assign rw  = ins[IMMW+3*RB-1 -: RB];
  assign ra  = ins[IMMW+2*RB-1 -: RB];
  assign rb  = ins[IMMW+RB-1 -: RB];
  assign imm = ins[IMMW-1:0];

  assign a      = rf[ra];
  assign b      = rf[rb];
  assign add_r  = {1'b0, a} + {1'b0, b};
  assign pc_inc = pc + PCW'(1);

  assign halted   = (state == S_HALT);
  assign dbg_data = rf[dbg_sel];

  always_comb begin
    state_n = state;
    pc_n    = pc;
    carry_n = carry;
    we      = 1'b0;
    wdata   = '0;
    retire  = 1'b0;
    if (state == S_RUN && run) begin
      retire = 1'b1;
      pc_n   = pc_inc;
      unique case (op)
        OP_ADD: begin
          we      = 1'b1;
          wdata   = add_r[W-1:0];
          carry_n = add_r[W];
        end
        OP_SUB: begin
          we      = 1'b1;
          wdata   = a - b;
          carry_n = (a < b);
        end
        OP_AND: begin
          we    = 1'b1;
          wdata = a & b;
        end
        OP_OR: begin
          we    = 1'b1;
          wdata = a | b;
        end
        OP_LDI: begin
          we    = 1'b1;
          wdata = imm[W-1:0];
        end
        OP_BEQ: begin
          if (a == b) pc_n = imm[PCW-1:0];
        end
        OP_JMP: pc_n = imm[PCW-1:0];
        OP_HALT: begin
          pc_n    = pc;
          state_n = S_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      pc      <= '0;
      carry   <= 1'b0;
      retired <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      carry <= carry_n;
      // saturate rather than wrap
      if (retire && retired != '1)
        retired <= retired + CNTW'(1);
      if (we) rf[rw] <= wdata;
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param at W=4, NREG=4, PCW=4, CNTW=8.
// Program memory lives here and feeds ins combinationally from pc.
module tb_datapath_param;

  localparam int IW = 13;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] AND_ = 3'b010;
  localparam logic [2:0] LDI  = 3'b100;
  localparam logic [2:0] BEQ  = 3'b101;
  localparam logic [2:0] JMP  = 3'b110;
  localparam logic [2:0] HLT  = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [IW-1:0] ins;
  logic [3:0]    pc;
  logic          halted;
  logic          carry;
  logic [7:0]    retired;
  logic [1:0]    dbg_sel = '0;
  logic [3:0]    dbg_data;

  logic [IW-1:0] prog [16];

  int errors = 0;
  int checks = 0;

  assign ins = prog[pc];

  always #5 clk = ~clk;

  datapath_param #(
    .W(4), .NREG(4), .PCW(4), .CNTW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .ins(ins),
    .pc(pc),
    .halted(halted),
    .carry(carry),
    .retired(retired),
    .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  function automatic logic [IW-1:0] enc(
    input logic [2:0] op,
    input int rw, input int ra, input int rb, input int imm
  );
    return {op, 2'(rw), 2'(ra), 2'(rb), 4'(imm)};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = enc(HLT, 0, 0, 0, 0);
  endtask

  task automatic reg_is(input string tag, input int r, input int exp);
    dbg_sel = 2'(r);
    #1;
    chk(tag, int'(dbg_data), exp);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Program 1: LDI/LDI/ADD/HALT, carry out of 7+9
    clr_prog();
    prog[0] = enc(LDI, 1, 0, 0, 7);
    prog[1] = enc(LDI, 2, 0, 0, 9);
    prog[2] = enc(ADD, 3, 1, 2, 0);
    prog[3] = enc(HLT, 0, 0, 0, 0);
    run = 1'b1;
    do_reset();
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_retired", int'(retired), 0);
    step(4);
    reg_is("p1_r3", 3, 0);
    reg_is("p1_r1", 1, 7);
    chk("p1_carry", int'(carry), 1);
    chk("p1_retired", int'(retired), 4);
    chk("p1_halted", int'(halted), 1);
    chk("p1_pc", int'(pc), 3);
    step(10);
    chk("p1_pc_hold", int'(pc), 3);
    chk("p1_ret_hold", int'(retired), 4);

    // Program 2: SUB borrow, then AND keeps carry
    clr_prog();
    prog[0] = enc(LDI, 1, 0, 0, 2);
    prog[1] = enc(LDI, 2, 0, 0, 5);
    prog[2] = enc(SUB, 0, 1, 2, 0);
    prog[3] = enc(AND_, 0, 1, 2, 0);
    do_reset();
    step(3);
    reg_is("sub_r0", 0, 13);
    chk("sub_carry", int'(carry), 1);
    step(1);
    reg_is("and_r0", 0, 0);
    chk("and_carry", int'(carry), 1);

    // Program 3: BEQ taken to 9, then not taken
    clr_prog();
    prog[0]  = enc(LDI, 1, 0, 0, 4);
    prog[1]  = enc(LDI, 2, 0, 0, 4);
    prog[2]  = enc(BEQ, 3, 1, 2, 9);
    prog[9]  = enc(LDI, 2, 0, 0, 5);
    prog[10] = enc(BEQ, 3, 1, 2, 0);
    do_reset();
    step(3);
    chk("beq_t_pc", int'(pc), 9);
    reg_is("beq_t_r3", 3, 0);
    step(2);
    chk("beq_n_pc", int'(pc), 11);
    reg_is("beq_n_r3", 3, 0);
    reg_is("beq_n_r1", 1, 4);
    chk("beq_carry", int'(carry), 0);

    // Program 4a: JMP to self at 15
    clr_prog();
    prog[0]  = enc(JMP, 0, 0, 0, 15);
    prog[15] = enc(JMP, 0, 0, 0, 15);
    do_reset();
    step(1);
    chk("jmp_pc", int'(pc), 15);
    step(2);
    chk("jmp_self_pc", int'(pc), 15);
    chk("jmp_retired", int'(retired), 3);

    // Program 4b: straight-line op at 15 wraps pc to 0
    prog[15] = enc(ADD, 0, 0, 0, 0);
    do_reset();
    step(2);
    chk("wrap_pc", int'(pc), 0);
    chk("wrap_retired", int'(retired), 2);

    // Program 5: stall for 5 cycles mid-program
    clr_prog();
    prog[0] = enc(LDI, 1, 0, 0, 3);
    prog[1] = enc(LDI, 2, 0, 0, 15);
    prog[2] = enc(ADD, 3, 1, 2, 0);
    prog[3] = enc(LDI, 0, 0, 0, 1);
    do_reset();
    step(3);
    run = 1'b0;
    step(5);
    chk("stall_pc", int'(pc), 3);
    chk("stall_carry", int'(carry), 1);
    chk("stall_retired", int'(retired), 3);
    reg_is("stall_r3", 3, 2);
    reg_is("stall_r0", 0, 0);
    run = 1'b1;
    step(1);
    chk("resume_pc", int'(pc), 4);
    reg_is("resume_r0", 0, 1);
    chk("resume_retired", int'(retired), 4);

    // Program 6: long loop saturates retired, then reset out of HALTED
    clr_prog();
    prog[0] = enc(LDI, 1, 0, 0, 15);
    prog[1] = enc(ADD, 2, 1, 1, 0);
    prog[2] = enc(JMP, 0, 0, 0, 2);
    do_reset();
    step(300);
    chk("sat_retired", int'(retired), 255);
    chk("sat_pc", int'(pc), 2);
    prog[2] = enc(HLT, 0, 0, 0, 0);
    step(1);
    chk("sat_halted", int'(halted), 1);
    chk("sat_ret_halt", int'(retired), 255);
    reg_is("sat_r2", 2, 14);
    chk("sat_carry", int'(carry), 1);
    do_reset();
    chk("hrst_pc", int'(pc), 0);
    chk("hrst_halted", int'(halted), 0);
    chk("hrst_carry", int'(carry), 0);
    chk("hrst_retired", int'(retired), 0);
    reg_is("hrst_r1", 1, 0);
    reg_is("hrst_r2", 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
